// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: round-robin packet grants between host
// requesters A/B, plus a full-framebuffer clear engine. Outputs registered.
module fb_write_arbiter #(
  parameter int COLOR_BITS  = 4,
  parameter int COLOR_COUNT = 3,
  parameter int ADDR_BITS   = 12
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              a_valid,
  output logic                              a_ready,
  input  logic [ADDR_BITS-1:0]              a_addr,
  input  logic [COLOR_BITS*COLOR_COUNT-1:0] a_pixel,
  input  logic                              a_last,
  input  logic                              b_valid,
  output logic                              b_ready,
  input  logic [ADDR_BITS-1:0]              b_addr,
  input  logic [COLOR_BITS*COLOR_COUNT-1:0] b_pixel,
  input  logic                              b_last,
  input  logic                              clear_start,
  input  logic [COLOR_BITS*COLOR_COUNT-1:0] clear_color,
  output logic                              clear_busy,
  output logic                              clear_done,
  output logic                              w_en,
  output logic [ADDR_BITS-1:0]              write_addr,
  output logic [COLOR_BITS*COLOR_COUNT-1:0] pixel_out
);
  localparam int PIXEL_BITS = COLOR_BITS * COLOR_COUNT;
  localparam logic [ADDR_BITS:0] CNT_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B, CLEAR} state_t;

  typedef struct packed {
    logic [ADDR_BITS-1:0]  addr;
    logic [PIXEL_BITS-1:0] pixel;
  } wr_t;

  state_t                state_q, state_d;
  logic                  rr_q, rr_d;            // 0: A preferred, 1: B preferred
  logic                  clear_pend_q, clear_pend_d;
  logic [PIXEL_BITS-1:0] clr_color_q, clr_color_d;
  logic [ADDR_BITS:0]    clr_cnt_q, clr_cnt_d;
  logic                  w_en_q, w_en_d;
  logic                  done_q, done_d;
  wr_t                   wr_q, wr_d;

  assign a_ready    = (state_q == GNT_A);
  assign b_ready    = (state_q == GNT_B);
  assign clear_busy = clear_pend_q | (state_q == CLEAR);
  assign w_en       = w_en_q;
  assign clear_done = done_q;
  assign write_addr = wr_q.addr;
  assign pixel_out  = wr_q.pixel;

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    clear_pend_d = clear_pend_q;
    clr_color_d  = clr_color_q;
    clr_cnt_d    = clr_cnt_q;
    wr_d         = wr_q;
    w_en_d       = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (clear_pend_q)                       state_d = CLEAR;
        else if (a_valid && (!b_valid || !rr_q)) state_d = GNT_A;
        else if (b_valid)                       state_d = GNT_B;
      end
      GNT_A: begin
        if (a_valid) begin
          w_en_d = 1'b1;
          wr_d   = '{addr: a_addr, pixel: a_pixel};
          if (a_last) begin
            state_d = IDLE;
            rr_d    = 1'b1;
          end
        end
      end
      GNT_B: begin
        if (b_valid) begin
          w_en_d = 1'b1;
          wr_d   = '{addr: b_addr, pixel: b_pixel};
          if (b_last) begin
            state_d = IDLE;
            rr_d    = 1'b0;
          end
        end
      end
      CLEAR: begin
        w_en_d = 1'b1;
        wr_d   = '{addr: clr_cnt_q[ADDR_BITS-1:0], pixel: clr_color_q};
        if (&clr_cnt_q[ADDR_BITS-1:0]) begin
          state_d      = IDLE;
          clear_pend_d = 1'b0;
          clr_cnt_d    = '0;
          done_d       = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // New clear requests only land while nothing is pending or running.
    if (clear_start && !clear_busy) begin
      clear_pend_d = 1'b1;
      clr_color_d  = clear_color;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      clear_pend_q <= 1'b0;
      clr_color_q  <= '0;
      clr_cnt_q    <= '0;
      w_en_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_q         <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      clear_pend_q <= clear_pend_d;
      clr_color_q  <= clr_color_d;
      clr_cnt_q    <= clr_cnt_d;
      w_en_q       <= w_en_d;
      done_q       <= done_d;
      wr_q         <= wr_d;
    end
  end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomized + directed bench for fb_write_arbiter against an in-bench
// ownership/scoreboard model, with literal checks on logged writes.
module tb_fb_write_arbiter;
  localparam int AW = 12, PW = 12, DEPTH = 1 << AW;
  localparam int OWN_N = 0, OWN_A = 1, OWN_B = 2, OWN_C = 3;

  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;

  logic a_valid, a_ready, a_last, b_valid, b_ready, b_last;
  logic [AW-1:0] a_addr, b_addr, write_addr;
  logic [PW-1:0] a_pixel, b_pixel, clear_color, pixel_out;
  logic clear_start, clear_busy, clear_done, w_en;

  fb_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_pixel(a_pixel), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_pixel(b_pixel), .b_last(b_last),
    .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
    .clear_done(clear_done), .w_en(w_en), .write_addr(write_addr), .pixel_out(pixel_out)
  );

  int checks = 0, errors = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: who owns the port, what gets written
  int            m_own = OWN_N, m_pref = OWN_A, m_idx = 0;
  logic          m_pend = 1'b0, m_wen = 1'b0, m_done = 1'b0;
  logic [PW-1:0] m_color = '0, m_pix = '0;
  logic [AW-1:0] m_addr = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_own <= OWN_N; m_pref <= OWN_A; m_idx <= 0; m_pend <= 1'b0;
      m_wen <= 1'b0; m_done <= 1'b0; m_color <= '0; m_pix <= '0; m_addr <= '0;
    end else begin
      m_wen  <= 1'b0;
      m_done <= 1'b0;
      if (m_own == OWN_A && a_valid) begin
        m_wen <= 1'b1; m_addr <= a_addr; m_pix <= a_pixel;
        if (a_last) begin m_own <= OWN_N; m_pref <= OWN_B; end
      end
      if (m_own == OWN_B && b_valid) begin
        m_wen <= 1'b1; m_addr <= b_addr; m_pix <= b_pixel;
        if (b_last) begin m_own <= OWN_N; m_pref <= OWN_A; end
      end
      if (m_own == OWN_C) begin
        m_wen <= 1'b1; m_addr <= m_idx[AW-1:0]; m_pix <= m_color;
        if (m_idx == DEPTH - 1) begin
          m_done <= 1'b1; m_own <= OWN_N; m_pend <= 1'b0; m_idx <= 0;
        end else m_idx <= m_idx + 1;
      end
      if (m_own == OWN_N) begin
        if (m_pend) m_own <= OWN_C;
        else if (a_valid && (!b_valid || m_pref == OWN_A)) m_own <= OWN_A;
        else if (b_valid) m_own <= OWN_B;
      end
      if (clear_start && !m_pend && m_own != OWN_C) begin
        m_pend <= 1'b1; m_color <= clear_color;
      end
    end
  end

  // ---------------- compare process
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({w_en, write_addr, pixel_out, clear_done, clear_busy, a_ready, b_ready} !==
          {m_wen, m_addr, m_pix, m_done, (m_pend || m_own == OWN_C), (m_own == OWN_A), (m_own == OWN_B)}) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t got wen=%b addr=%h pix=%h done=%b busy=%b ar=%b br=%b want wen=%b addr=%h pix=%h done=%b busy=%b ar=%b br=%b",
                 $time, w_en, write_addr, pixel_out, clear_done, clear_busy, a_ready, b_ready,
                 m_wen, m_addr, m_pix, m_done, (m_pend || m_own == OWN_C), (m_own == OWN_A), (m_own == OWN_B));
      end
    end
  end

  // ---------------- write / grant log
  typedef struct { logic [AW-1:0] addr; logic [PW-1:0] pix; logic done; int cyc; } wr_t;
  wr_t wlog[$];
  int  glog[$];
  int  cyc = 0, bseen = 0;

  always @(negedge clk) begin
    cyc++;
    if (w_en === 1'b1) wlog.push_back('{write_addr, pixel_out, clear_done, cyc});
    if (a_valid && a_ready === 1'b1 && a_last) glog.push_back(OWN_A);
    if (b_valid && b_ready === 1'b1 && b_last) glog.push_back(OWN_B);
    if (b_ready === 1'b1) bseen++;
  end

  // ---------------- requester drivers (queue of beats, optional idle gap before each)
  typedef struct { logic [AW-1:0] addr; logic [PW-1:0] pix; logic last; int gap; } beat_t;
  beat_t qa[$], qb[$];
  int ga = 0, gb = 0;
  logic ta, tb;

  always begin
    @(negedge clk);
    ta = a_valid && a_ready;
    tb = b_valid && b_ready;
    @(posedge clk);
    #1;
    if (ta) begin if (qa.size() > 0) void'(qa.pop_front()); a_valid = 1'b0; end
    if (tb) begin if (qb.size() > 0) void'(qb.pop_front()); b_valid = 1'b0; end
    if (!a_valid && qa.size() > 0) begin
      if (ga < qa[0].gap) ga++;
      else begin ga = 0; a_valid = 1'b1; a_addr = qa[0].addr; a_pixel = qa[0].pix; a_last = qa[0].last; end
    end
    if (!b_valid && qb.size() > 0) begin
      if (gb < qb[0].gap) gb++;
      else begin gb = 0; b_valid = 1'b1; b_addr = qb[0].addr; b_pixel = qb[0].pix; b_last = qb[0].last; end
    end
  end

  task automatic push_pkt(input int side, input logic [AW-1:0] base, input int len,
                          input int gap_first, input int gap_mid_at, input int gap_mid);
    beat_t bt;
    for (int i = 0; i < len; i++) begin
      bt.addr = base + AW'(i);
      bt.pix  = PW'($urandom);
      bt.last = (i == len - 1);
      bt.gap  = (i == 0) ? gap_first : ((i == gap_mid_at) ? gap_mid : 0);
      if (side == OWN_A) qa.push_back(bt); else qb.push_back(bt);
    end
  endtask

  task automatic flush();
    qa.delete(); qb.delete(); ga = 0; gb = 0;
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3; rst_n = 1'b0;
    flush();
    @(posedge clk); #3; rst_n = 1'b1;
  endtask

  task automatic pulse_clear(input logic [PW-1:0] c);
    @(posedge clk); #2; clear_start = 1'b1; clear_color = c;
    @(posedge clk); #2; clear_start = 1'b0; clear_color = PW'($urandom);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (!(qa.size() == 0 && qb.size() == 0 && !a_valid && !b_valid &&
             clear_busy === 1'b0 && a_ready === 1'b0 && b_ready === 1'b0) && n < max) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= max) begin errors++; $display("FAIL wait_idle timeout after %0d cycles", max); end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_clear(input int s, input logic [PW-1:0] c);
    int bad = 0, dn = 0;
    chk("clear_len_avail", (wlog.size() >= s + DEPTH), 1);
    if (wlog.size() < s + DEPTH) return;
    for (int i = 0; i < DEPTH; i++) begin
      if (wlog[s+i].addr != AW'(i) || wlog[s+i].pix != c) bad++;
      if (wlog[s+i].done) begin dn++; if (i != DEPTH - 1) bad++; end
    end
    chk("clear_bad_writes", bad, 0);
    chk("clear_done_count", dn, 1);
    chk("clear_no_gaps", wlog[s+DEPTH-1].cyc - wlog[s].cyc, DEPTH - 1);
  endtask

  initial begin
    int n0, n1, g0, w;
    int exp_g[4]    = '{OWN_A, OWN_B, OWN_A, OWN_B};
    int exp_a2[8]   = '{'h100, 'h101, 'h300, 'h301, 'h110, 'h111, 'h310, 'h311};
    int exp_a3[5]   = '{'h400, 'h401, 'h402, 'h500, 'h501};
    a_valid = 0; b_valid = 0; a_last = 0; b_last = 0; a_addr = 0; b_addr = 0;
    a_pixel = 0; b_pixel = 0; clear_start = 0; clear_color = 0;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // reset mid-stream: outputs drop without waiting for a clock
    push_pkt(OWN_A, 12'h200, 8, 0, 0, 0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_w_en", w_en, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_write_addr", write_addr, 0);
    chk("rst_pixel_out", pixel_out, 0);
    chk("rst_clear_busy", clear_busy, 0);
    flush();
    @(posedge clk); #3 rst_n = 1'b1;

    // single A packet of 3
    n0 = wlog.size(); bseen = 0;
    push_pkt(OWN_A, 12'h010, 3, 0, 0, 0);
    wait_idle(50);
    chk("t1_count", wlog.size() - n0, 3);
    if (wlog.size() >= n0 + 3) begin
      for (int i = 0; i < 3; i++) chk("t1_addr", wlog[n0+i].addr, 'h010 + i);
      chk("t1_back_to_back", wlog[n0+2].cyc - wlog[n0].cyc, 2);
    end
    chk("t1_b_ready_never", bseen, 0);

    // round robin, two 2-beat packets each side
    do_reset();
    n0 = wlog.size(); g0 = glog.size();
    push_pkt(OWN_A, 12'h100, 2, 0, 0, 0); push_pkt(OWN_A, 12'h110, 2, 0, 0, 0);
    push_pkt(OWN_B, 12'h300, 2, 0, 0, 0); push_pkt(OWN_B, 12'h310, 2, 0, 0, 0);
    wait_idle(100);
    chk("t2_grants", glog.size() - g0, 4);
    if (glog.size() >= g0 + 4) for (int i = 0; i < 4; i++) chk("t2_grant_order", glog[g0+i], exp_g[i]);
    chk("t2_count", wlog.size() - n0, 8);
    if (wlog.size() >= n0 + 8) begin
      for (int i = 0; i < 8; i++) chk("t2_addr", wlog[n0+i].addr, exp_a2[i]);
      chk("t2_span_one_bubble", wlog[n0+7].cyc - wlog[n0].cyc, 10);
    end

    // atomicity: A stalls 5 cycles mid-packet while B waits
    n0 = wlog.size(); g0 = glog.size();
    push_pkt(OWN_A, 12'h400, 3, 0, 1, 5);
    push_pkt(OWN_B, 12'h500, 2, 0, 0, 0);
    wait_idle(100);
    chk("t3_count", wlog.size() - n0, 5);
    if (wlog.size() >= n0 + 5) begin
      for (int i = 0; i < 5; i++) chk("t3_addr", wlog[n0+i].addr, exp_a3[i]);
      chk("t3_gap", wlog[n0+1].cyc - wlog[n0].cyc, 6);
    end
    if (glog.size() >= g0 + 2) begin
      chk("t3_first_A", glog[g0], OWN_A); chk("t3_then_B", glog[g0+1], OWN_B);
    end else chk("t3_grants", glog.size() - g0, 2);

    // clear from idle
    n0 = wlog.size();
    pulse_clear(12'hF00);
    chk("t4_busy_next_cycle", clear_busy, 1);
    wait_idle(DEPTH + 50);
    chk("t4_count", wlog.size() - n0, DEPTH);
    check_clear(n0, 12'hF00);
    chk("t4_busy_low", clear_busy, 0);

    // clear deferred behind B, second request ignored, A held off
    n0 = wlog.size();
    push_pkt(OWN_B, 12'h600, 6, 0, 0, 0);
    repeat (3) @(posedge clk);
    pulse_clear(12'hF00);
    repeat (20) @(posedge clk);
    pulse_clear(12'h0F0);
    push_pkt(OWN_A, 12'h700, 1, 0, 0, 0);
    wait_idle(DEPTH + 100);
    chk("t5_count", wlog.size() - n0, DEPTH + 7);
    if (wlog.size() >= n0 + DEPTH + 7) begin
      for (int i = 0; i < 6; i++) chk("t5_b_addr", wlog[n0+i].addr, 'h600 + i);
      check_clear(n0 + 6, 12'hF00);
      chk("t5_a_after", wlog[n0+DEPTH+6].addr, 'h700);
    end

    // reset in the middle of a clear
    pulse_clear(12'h00F);
    w = 0;
    while (!(w_en === 1'b1 && write_addr == 12'd1000) && w < 2000) begin @(negedge clk); w++; end
    chk("t6_reached_1000", (w < 2000), 1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("t6_busy_async", clear_busy, 0);
    chk("t6_wen_async", w_en, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    n1 = wlog.size();
    repeat (20) @(negedge clk);
    chk("t6_no_resume", wlog.size(), n1);

    // randomized traffic with one clear in the middle
    for (int it = 0; it < 400; it++) begin
      @(posedge clk);
      if (qa.size() < 4 && $urandom_range(0, 3) == 0)
        push_pkt(OWN_A, AW'($urandom), $urandom_range(1, 4), $urandom_range(0, 2), 1, $urandom_range(0, 2));
      if (qb.size() < 4 && $urandom_range(0, 3) == 0)
        push_pkt(OWN_B, AW'($urandom), $urandom_range(1, 4), $urandom_range(0, 2), 2, $urandom_range(0, 2));
      if (it == 150) pulse_clear(PW'($urandom));
    end
    wait_idle(DEPTH + 500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
